popcount_sequencer: RTL

//  Computes the number of set bits in a DATA_W-bit operand.

---
 rtl/popcount_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/popcount_sequencer.sv
// Sequential popcount: one 16:5 GPC compressor is reused over DATA_W/16 cycles,
// one 16-bit slice per cycle, and the slice counts are summed into a CNT_W result.

// 16-input population count built as a balanced adder tree (2 -> 3 -> 4 -> 5 bits).
module gpc_16_5 (
  input  logic [15:0] bits,
  output logic [4:0]  count
);

  logic [1:0] lvl1 [8];
  logic [2:0] lvl2 [4];
  logic [3:0] lvl3 [2];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lvl1[i] = {1'b0, bits[2*i]} + {1'b0, bits[2*i+1]};
    end
    for (int i = 0; i < 4; i++) begin
      lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
    end
    count = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};
  end

endmodule

module popcount_sequencer #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int NSLICE = DATA_W / 16;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((DATA_W < 16) || (DATA_W % 16 != 0)) begin : g_bad_data_w
      $error("popcount_sequencer: DATA_W must be a multiple of 16 and >= 16");
    end
    if (CNT_W != $clog2(DATA_W + 1)) begin : g_bad_cnt_w
      $error("popcount_sequencer: CNT_W must equal $clog2(DATA_W+1)");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The producer holds valid/data until the transfer; the result is held
  // stable in DONE until out_ready is seen.
  logic [1:0]        state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  acc_q;
  logic [IDX_W-1:0]  idx_q;
  logic [4:0]        slice_cnt;
  logic              accept;
  logic              last_slice;

  gpc_16_5 u_gpc (
    .bits  (shift_q[15:0]),
    .count (slice_cnt)
  );

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));
  assign out_valid  = (state_q == DONE);
  assign out_count  = acc_q;
  assign busy       = (state_q == RUN) || (state_q == DONE);
  assign state_dbg  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= in_data;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_q + {{(CNT_W-5){1'b0}}, slice_cnt};
          shift_q <= shift_q >> 16;
          idx_q   <= idx_q + 1'b1;
          if (last_slice) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // in_ready mirrors out_ready here, so a new operand can only be
          // taken on the same edge the result leaves.
          if (out_ready) begin
            if (in_valid) begin
              shift_q <= in_data;
              acc_q   <= '0;
              idx_q   <= '0;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
